// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter: grant owner encoding,
// arbitration state and the round-robin tie-break helper.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_LOAD = 2'd2
  } owner_e;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  // On a tie the requester that did not win last time gets the grant.
  function automatic owner_e tie_winner(input owner_e last_winner);
    owner_e win;
    if (last_winner == OWN_LOAD) begin
      win = OWN_CORE;
    end else begin
      win = OWN_LOAD;
    end
    return win;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Bundle of the core, loader and memory-side signals around the arbiter.
// The slave view belongs to the arbiter, the master view to its surroundings.
interface data_mem_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
);

  logic              core_valid;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_ready;
  logic              core_stall;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              ld_valid;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_lock;
  logic              ld_ready;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;

  logic              mem_read_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic [DATA_W-1:0] mem_read_data;

  logic [1:0]        owner;

  modport slave (
    input  core_valid, core_we, core_addr, core_wdata,
    input  ld_valid, ld_we, ld_addr, ld_wdata, ld_lock,
    input  mem_read_data,
    output core_ready, core_stall, core_rvalid, core_rdata,
    output ld_ready, ld_rvalid, ld_rdata,
    output mem_read_en, mem_write_en, mem_address, mem_write_data,
    output owner
  );

  modport master (
    output core_valid, core_we, core_addr, core_wdata,
    output ld_valid, ld_we, ld_addr, ld_wdata, ld_lock,
    output mem_read_data,
    input  core_ready, core_stall, core_rvalid, core_rdata,
    input  ld_ready, ld_rvalid, ld_rdata,
    input  mem_read_en, mem_write_en, mem_address, mem_write_data,
    input  owner
  );

endinterface

// File: rtl/data_mem_arbiter_rsp_slot.sv
// Read-return register for one requester: captures load data on an accepted
// load and raises rvalid for exactly the following cycle.
module arb_rsp_slot #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o
);

  logic              rvalid_q;
  logic              rvalid_d;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Next-state: rvalid follows capture, rdata holds until the next load.
  always_comb begin
    rvalid_d = capture_i;
    rdata_d  = rdata_q;
    if (capture_i) begin
      rdata_d = data_i;
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Response registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  // Outputs read as zero in any reset cycle, so a load in flight never returns.
  assign rvalid_o = rvalid_q & ~rst;
  assign rdata_o  = rst ? {DATA_W{1'b0}} : rdata_q;

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-ported data memory between the core
// load/store path and the loader/debug port, with a bounded locked burst.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W    = ADDR_W_DEF,
  parameter int unsigned DATA_W    = DATA_W_DEF,
  parameter int unsigned MAX_BURST = 8
) (
  input logic               clk,
  input logic               rst,
  data_mem_arbiter_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  arb_state_e       state_q;
  arb_state_e       state_d;
  owner_e           last_winner_q;
  owner_e           last_winner_d;
  logic [CNT_W-1:0] burst_cnt_q;
  logic [CNT_W-1:0] burst_cnt_d;

  owner_e           grant_s;
  logic             lock_hold_s;
  logic [CNT_W-1:0] burst_next_s;
  logic             core_load_s;
  logic             ld_load_s;
  logic             core_rvalid_s;
  logic             ld_rvalid_s;
  logic [DATA_W-1:0] core_rdata_s;
  logic [DATA_W-1:0] ld_rdata_s;

  // A lock only holds while the loader keeps its valid up.
  assign lock_hold_s = (state_q == ARB_LOCKED) && bus.ld_valid;

  // Grant selection from state, valids and the last winner.
  always_comb begin
    grant_s = OWN_NONE;
    if (rst) begin
      grant_s = OWN_NONE;
    end else if (lock_hold_s) begin
      grant_s = OWN_LOAD;
    end else if (bus.core_valid && bus.ld_valid) begin
      grant_s = tie_winner(last_winner_q);
    end else if (bus.core_valid) begin
      grant_s = OWN_CORE;
    end else if (bus.ld_valid) begin
      grant_s = OWN_LOAD;
    end else begin
      grant_s = OWN_NONE;
    end
  end

  // Handshake outputs and memory drive from the winner.
  always_comb begin
    bus.core_ready     = 1'b0;
    bus.ld_ready       = 1'b0;
    bus.mem_read_en    = 1'b0;
    bus.mem_write_en   = 1'b0;
    bus.mem_address    = '0;
    bus.mem_write_data = '0;
    case (grant_s)
      OWN_CORE: begin
        bus.core_ready     = 1'b1;
        bus.mem_read_en    = ~bus.core_we;
        bus.mem_write_en   = bus.core_we;
        bus.mem_address    = bus.core_addr;
        bus.mem_write_data = bus.core_wdata;
      end
      OWN_LOAD: begin
        bus.ld_ready       = 1'b1;
        bus.mem_read_en    = ~bus.ld_we;
        bus.mem_write_en   = bus.ld_we;
        bus.mem_address    = bus.ld_addr;
        bus.mem_write_data = bus.ld_wdata;
      end
      default: begin
        bus.core_ready     = 1'b0;
        bus.ld_ready       = 1'b0;
      end
    endcase
  end

  assign bus.core_stall = bus.core_valid & ~bus.core_ready;
  assign bus.owner      = grant_s;

  // A loader beat continues a held burst, otherwise it starts a fresh one.
  assign burst_next_s = lock_hold_s ? (burst_cnt_q + CNT_ONE) : CNT_ONE;

  // FSM next state, burst counter and round-robin history.
  always_comb begin
    state_d       = state_q;
    burst_cnt_d   = burst_cnt_q;
    last_winner_d = last_winner_q;
    if ((state_q == ARB_LOCKED) && !bus.ld_valid) begin
      state_d     = ARB_IDLE;
      burst_cnt_d = '0;
    end else begin
      state_d     = state_q;
    end
    case (grant_s)
      OWN_CORE: begin
        last_winner_d = OWN_CORE;
      end
      OWN_LOAD: begin
        last_winner_d = OWN_LOAD;
        if (bus.ld_lock && (burst_next_s < CNT_MAX)) begin
          state_d     = ARB_LOCKED;
          burst_cnt_d = burst_next_s;
        end else begin
          // Lock released by the loader or forced out at the burst limit.
          state_d     = ARB_IDLE;
          burst_cnt_d = '0;
        end
      end
      default: begin
        last_winner_d = last_winner_q;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ARB_IDLE;
      burst_cnt_q   <= '0;
      last_winner_q <= OWN_LOAD;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      last_winner_q <= last_winner_d;
    end
  end

  assign core_load_s = (grant_s == OWN_CORE) && !bus.core_we;
  assign ld_load_s   = (grant_s == OWN_LOAD) && !bus.ld_we;

  arb_rsp_slot #(.DATA_W(DATA_W)) u_core_slot (
    .clk       (clk),
    .rst       (rst),
    .capture_i (core_load_s),
    .data_i    (bus.mem_read_data),
    .rvalid_o  (core_rvalid_s),
    .rdata_o   (core_rdata_s)
  );

  arb_rsp_slot #(.DATA_W(DATA_W)) u_ld_slot (
    .clk       (clk),
    .rst       (rst),
    .capture_i (ld_load_s),
    .data_i    (bus.mem_read_data),
    .rvalid_o  (ld_rvalid_s),
    .rdata_o   (ld_rdata_s)
  );

  assign bus.core_rvalid = core_rvalid_s;
  assign bus.core_rdata  = core_rdata_s;
  assign bus.ld_rvalid   = ld_rvalid_s;
  assign bus.ld_rdata    = ld_rdata_s;

endmodule
